// File: rtl/dcp_pass_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcp_pass_sequencer_pkg
// Description : Shared state encoding and pixel-width helper for the
//               dehaze pass sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package dcp_pass_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EST      = 2'd1,
        ST_EST_WAIT = 2'd2,
        ST_REC      = 2'd3
    } state_t;

    function automatic int pix_width(input int channels, input int data_w);
        return channels * data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcp_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dcp_sync_fifo
// Description : Single-clock show-ahead FIFO with registered programmable-full
//               flag and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module dcp_sync_fifo #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 64,
    parameter int PROG_FULL = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_valid,
    output logic             o_prog_full,
    output logic             o_overflow
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_prog_full;
    logic             r_overflow;
    logic             w_full;
    logic             w_rd;
    logic             w_wr;

    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_rd   = i_rd_en && (r_count != '0);
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_wr   = i_wr_en && (!w_full || w_rd);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_prog_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_prog_full <= (w_count_nxt >= c_CW'(PROG_FULL));
            if (i_wr_en && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_valid     = (r_count != '0);
    assign o_prog_full = r_prog_full;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: rtl/dcp_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dcp_pass_sequencer
// Description : Sequences estimation and recovery passes over pixel frames and
//               buffers recovered (or bypassed) pixels in an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module dcp_pass_sequencer
    import dcp_pass_sequencer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int CHANNELS   = 3,
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int FIFO_DEPTH = 64,
    parameter int PROG_FULL  = FIFO_DEPTH - 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         bypass,
    input  logic                         reestimate,
    input  logic [CHANNELS*DATA_W-1:0]   s_tdata,
    input  logic                         s_tvalid,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic                         est_valid,
    output logic                         rec_valid,
    output logic [CHANNELS*DATA_W-1:0]   pix_data,
    input  logic                         est_done,
    input  logic                         r_valid,
    input  logic [CHANNELS*DATA_W-1:0]   r_data,
    output logic [CHANNELS*DATA_W-1:0]   m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic                         intr_est,
    output logic                         intr_frame,
    output logic                         err_tlast,
    output logic                         overflow
);
    localparam int c_PW    = pix_width(CHANNELS, DATA_W);
    localparam int c_NPIX  = IMG_W * IMG_H;
    localparam int c_CNT_W = $clog2(c_NPIX + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(c_NPIX - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_bypass;
    logic [c_CNT_W-1:0] r_in_cnt;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic               r_est_valid;
    logic               r_rec_valid;
    logic               r_byp_wr;
    logic [c_PW-1:0]    r_pix;
    logic               r_err_tlast;

    logic               w_s_tready;
    logic               w_intr_est;
    logic               w_accept;
    logic               w_in_last;
    logic               w_out_hs;
    logic               w_out_last;
    logic               w_prog_full;
    logic               w_fifo_valid;
    logic               w_fifo_wr;
    logic [c_PW-1:0]    w_fifo_din;

    assign w_accept   = s_tvalid && w_s_tready;
    assign w_in_last  = (r_in_cnt == c_LAST_IDX);
    assign w_out_hs   = w_fifo_valid && m_tready;
    assign w_out_last = (r_out_cnt == c_LAST_IDX);

    always_comb begin
        w_state_nxt = r_state;
        w_s_tready  = 1'b0;
        w_intr_est  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = bypass ? ST_REC : ST_EST;
                end
            end
            ST_EST: begin
                w_s_tready = enable;
                if (w_accept && w_in_last) begin
                    w_state_nxt = ST_EST_WAIT;
                end
            end
            ST_EST_WAIT: begin
                if (est_done) begin
                    w_state_nxt = ST_REC;
                    w_intr_est  = 1'b1;
                end
            end
            ST_REC: begin
                w_s_tready = enable && !w_prog_full;
                if (w_accept && w_in_last && reestimate) begin
                    w_state_nxt = ST_EST;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bypass    <= 1'b0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_est_valid <= 1'b0;
            r_rec_valid <= 1'b0;
            r_byp_wr    <= 1'b0;
            r_pix       <= '0;
            r_err_tlast <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && enable) begin
                r_bypass <= bypass;
            end
            r_est_valid <= w_accept && (r_state == ST_EST);
            r_rec_valid <= w_accept && (r_state == ST_REC) && !r_bypass;
            r_byp_wr    <= w_accept && (r_state == ST_REC) && r_bypass;
            if (w_accept) begin
                r_pix <= s_tdata;
            end
            // Counting follows beat count alone; a misplaced tlast only flags.
            if (r_state == ST_IDLE || r_state == ST_EST_WAIT) begin
                r_in_cnt <= '0;
            end else if (w_accept) begin
                r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
            end
            if (w_accept && (s_tlast != w_in_last)) begin
                r_err_tlast <= 1'b1;
            end
            if (w_out_hs) begin
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
            end
        end
    end

    assign w_fifo_wr  = r_bypass ? r_byp_wr : r_valid;
    assign w_fifo_din = r_bypass ? r_pix : r_data;

    dcp_sync_fifo #(
        .WIDTH     (c_PW),
        .DEPTH     (FIFO_DEPTH),
        .PROG_FULL (PROG_FULL)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_fifo_wr),
        .i_wr_data   (w_fifo_din),
        .i_rd_en     (m_tready),
        .o_rd_data   (m_tdata),
        .o_valid     (w_fifo_valid),
        .o_prog_full (w_prog_full),
        .o_overflow  (overflow)
    );

    assign s_tready   = w_s_tready;
    assign est_valid  = r_est_valid;
    assign rec_valid  = r_rec_valid;
    assign pix_data   = r_pix;
    assign m_tvalid   = w_fifo_valid;
    assign m_tlast    = w_fifo_valid && w_out_last;
    assign intr_est   = w_intr_est;
    assign intr_frame = w_out_hs && w_out_last;
    assign err_tlast  = r_err_tlast;

endmodule
`default_nettype wire

// File: tb/tb_dcp_pass_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcp_pass_sequencer
// Description : Self-checking bench: vector table, directed sequences and a
//               randomized run against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcp_pass_sequencer;
    localparam int NPIX  = 8;
    localparam int PF    = 6;
    localparam int DEPTH = 8;
    localparam logic [23:0] XK = 24'h5A5A5A;

    localparam int S_IDLE = 0;
    localparam int S_EST  = 1;
    localparam int S_WAIT = 2;
    localparam int S_REC  = 3;

    logic        clk = 1'b0;
    logic        rst, enable, bypass, reestimate, est_done;
    logic [23:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic        est_valid, rec_valid;
    logic [23:0] pix_data;
    logic        r_valid;
    logic [23:0] r_data;
    logic [23:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic        intr_est, intr_frame, err_tlast, overflow;

    // Recovery engine stand-in: echoes each pixel, lightly transformed.
    assign r_valid = rec_valid;
    assign r_data  = pix_data ^ XK;

    always #5 clk = ~clk;

    dcp_pass_sequencer #(
        .DATA_W(8), .CHANNELS(3), .IMG_W(4), .IMG_H(2), .FIFO_DEPTH(8), .PROG_FULL(6)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .bypass(bypass), .reestimate(reestimate),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .est_valid(est_valid), .rec_valid(rec_valid), .pix_data(pix_data),
        .est_done(est_done), .r_valid(r_valid), .r_data(r_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .intr_est(intr_est), .intr_frame(intr_frame), .err_tlast(err_tlast),
        .overflow(overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pass mode, beat positions and FIFO contents as a queue.
    int          ms, mcnt, mout;
    bit          mbyp, merr, movf, m_estv, m_recv, m_pend;
    logic [23:0] m_pend_d, m_pix;
    logic [23:0] mq[$];

    function automatic bit model_ready();
        return enable && (ms == S_EST || (ms == S_REC && mq.size() < PF));
    endfunction

    task automatic model_reset();
        ms = S_IDLE; mcnt = 0; mout = 0;
        mbyp = 0; merr = 0; movf = 0; m_estv = 0; m_recv = 0; m_pend = 0;
        m_pend_d = '0; m_pix = '0;
        mq.delete();
    endtask

    task automatic model_check();
        bit e_mv;
        e_mv = (mq.size() > 0);
        chk1("s_tready", s_tready, model_ready());
        chk1("m_tvalid", m_tvalid, e_mv);
        if (e_mv) begin
            chkd("m_tdata", m_tdata, mq[0]);
            chk1("m_tlast", m_tlast, mout == NPIX - 1);
        end
        chk1("intr_frame", intr_frame, e_mv && m_tready && mout == NPIX - 1);
        chk1("intr_est", intr_est, ms == S_WAIT && est_done);
        chk1("est_valid", est_valid, m_estv);
        chk1("rec_valid", rec_valid, m_recv);
        chkd("pix_data", pix_data, m_pix);
        chk1("err_tlast", err_tlast, merr);
        chk1("overflow", overflow, movf);
    endtask

    task automatic model_step();
        bit acc, last;
        acc  = s_tvalid && model_ready();
        last = (mcnt == NPIX - 1);
        if (mq.size() > 0 && m_tready) begin
            void'(mq.pop_front());
            mout = (mout == NPIX - 1) ? 0 : mout + 1;
        end
        if (m_pend) begin
            if (mq.size() < DEPTH) mq.push_back(m_pend_d);
            else movf = 1;
        end
        m_estv   = acc && ms == S_EST;
        m_recv   = acc && ms == S_REC && !mbyp;
        m_pend   = acc && ms == S_REC;
        m_pend_d = mbyp ? s_tdata : (s_tdata ^ XK);
        if (acc) begin
            m_pix = s_tdata;
            if (s_tlast != last) merr = 1;
            mcnt = last ? 0 : mcnt + 1;
        end
        case (ms)
            S_IDLE: if (enable) begin mbyp = bypass; ms = bypass ? S_REC : S_EST; end
            S_EST:  if (acc && last) ms = S_WAIT;
            S_WAIT: if (est_done) ms = S_REC;
            S_REC:  if (acc && last && reestimate) ms = S_EST;
            default: ;
        endcase
    endtask

    task automatic cyc(input bit v, input bit l, input logic [23:0] d, input bit mr);
        s_tvalid = v; s_tlast = l; s_tdata = d; m_tready = mr;
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic beats(input int n, input bit mr);
        for (int i = 0; i < n; i++) cyc(1'b1, mcnt == NPIX - 1, 24'($urandom), mr);
    endtask

    task automatic align_frame();
        for (int k = 0; k < 20 && mcnt != 0; k++) cyc(1'b1, mcnt == NPIX - 1, 24'($urandom), 1'b1);
    endtask

    task automatic idle(input int n, input bit mr);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 24'h0, mr);
    endtask

    task automatic rnd_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            enable     = ($urandom_range(9) != 0);
            bypass     = ($urandom_range(1) != 0);
            est_done   = ($urandom_range(3) == 0);
            reestimate = ($urandom_range(1) != 0);
            cyc($urandom_range(3) != 0, mcnt == NPIX - 1, 24'($urandom), $urandom_range(2) != 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        m_tready = 1'b0; est_done = 1'b0; reestimate = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_reset_outputs();
        chk1("rst_s_tready", s_tready, 1'b0);
        chk1("rst_est_valid", est_valid, 1'b0);
        chk1("rst_rec_valid", rec_valid, 1'b0);
        chk1("rst_m_tvalid", m_tvalid, 1'b0);
        chk1("rst_m_tlast", m_tlast, 1'b0);
        chk1("rst_intr_est", intr_est, 1'b0);
        chk1("rst_intr_frame", intr_frame, 1'b0);
        chk1("rst_err_tlast", err_tlast, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chkd("rst_pix_data", pix_data, 24'h0);
    endtask

    typedef struct {
        bit vld; bit last; bit done;
        bit e_rdy; bit e_est; bit e_intr;
    } vec_t;
    vec_t tbl[13];

    initial begin
        // Estimation pass from reset: IDLE, 8 beats, wait, est_done, REC.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 2; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        bypass = 1'b0;
        do_reset();
        chk_reset_outputs();

        enable = 1'b1;
        for (int i = 0; i < 13; i++) begin
            s_tvalid = tbl[i].vld; s_tlast = tbl[i].last; est_done = tbl[i].done;
            s_tdata  = 24'(i);
            @(negedge clk);
            chk1($sformatf("tbl%0d_s_tready", i), s_tready, tbl[i].e_rdy);
            chk1($sformatf("tbl%0d_est_valid", i), est_valid, tbl[i].e_est);
            chk1($sformatf("tbl%0d_intr_est", i), intr_est, tbl[i].e_intr);
            @(posedge clk);
            #1;
        end

        // Model-checked directed sequences.
        do_reset();
        enable = 1'b1; bypass = 1'b0;
        idle(1, 1'b1);
        beats(8, 1'b1);
        idle(2, 1'b1);
        est_done = 1'b1; idle(1, 1'b1); est_done = 1'b0;
        beats(8, 1'b1);
        idle(4, 1'b1);

        beats(12, 1'b0);
        chk1("stall_s_tready", s_tready, 1'b0);
        chk1("stall_overflow", overflow, 1'b0);
        idle(12, 1'b1);

        align_frame();
        for (int i = 0; i < NPIX; i++) cyc(1'b1, mcnt == 4, 24'($urandom), 1'b1);
        chk1("tlast_err_set", err_tlast, 1'b1);
        idle(4, 1'b1);
        chk1("tlast_err_sticky", err_tlast, 1'b1);

        align_frame();
        reestimate = 1'b1; beats(8, 1'b1); reestimate = 1'b0;
        beats(8, 1'b1);
        est_done = 1'b1; idle(1, 1'b1); est_done = 1'b0;
        beats(3, 1'b1);

        // Reset mid-frame, then a bypass run.
        do_reset();
        chk_reset_outputs();
        enable = 1'b1; bypass = 1'b1;
        idle(1, 1'b0);
        cyc(1'b1, 1'b0, 24'hC0FFEE, 1'b0);
        chk1("byp_lat1_m_tvalid", m_tvalid, 1'b0);
        idle(1, 1'b0);
        chk1("byp_lat2_m_tvalid", m_tvalid, 1'b1);
        chkd("byp_lat2_m_tdata", m_tdata, 24'hC0FFEE);
        rnd_cycles(250);

        do_reset();
        bypass = 1'b0;
        rnd_cycles(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
